// File: rtl/mvm_result_drain.sv
// Result drain for the MVM: captures y on the falling edge of isAcc, requantizes
// each word to NUM_BIT signed (round + saturate) and streams it out over valid/ready.
module mvm_result_drain #(
  parameter int NUM_BIT = 8,
  parameter int DIM     = 8,
  parameter int SHIFT   = 4
) (
  input  logic                         i_clk_drain,
  input  logic                         i_rst_drain,
  input  logic [DIM-1:0][NUM_BIT+7:0]  i_y_vector,
  input  logic                         i_isAcc,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [NUM_BIT-1:0]           o_data,
  output logic [$clog2(DIM)-1:0]       o_idx,
  output logic                         o_last,
  output logic                         o_sat,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_overrun
);

  localparam int IW    = NUM_BIT + 8;
  localparam int EW    = NUM_BIT + 9;
  localparam int IDX_W = $clog2(DIM);

  localparam logic signed [EW-1:0] HALF  = EW'(1) << (SHIFT - 1);
  localparam logic signed [EW-1:0] MAX_V = EW'((2 ** (NUM_BIT - 1)) - 1);
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state_q, state_n;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic                   isacc_d;
  logic                   overrun_q, overrun_n;
  logic                   done_q;
  logic [DIM-1:0][IW-1:0] buf_q;

  logic cap, xfer, idx_last, load;

  logic [IW-1:0]          word;
  logic signed [EW-1:0]   ext, rnd, shr;
  logic [NUM_BIT-1:0]     q_word;
  logic                   sat;

  assign cap      = isacc_d & ~i_isAcc;
  assign xfer     = (state_q == STREAM) & i_ready;
  assign idx_last = (idx_q == IDX_W'(DIM - 1));

  always_ff @(posedge i_clk_drain) begin
    if (i_rst_drain) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      isacc_d   <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      isacc_d   <= i_isAcc;
      overrun_q <= overrun_n;
      done_q    <= xfer & idx_last;
    end
  end

  // Buffer needs no reset: it is only ever read while streaming after a load.
  always_ff @(posedge i_clk_drain) begin
    if (load) begin
      buf_q <= i_y_vector;
    end
  end

  // A capture coinciding with the final transfer chains straight into a new stream.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    overrun_n = overrun_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          state_n = STREAM;
          idx_n   = '0;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (xfer && idx_last) begin
          idx_n = '0;
          if (cap) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_n = idx_q + 1'b1;
          end
          if (cap) begin
            overrun_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    word   = buf_q[idx_q];
    ext    = {word[IW-1], word};
    rnd    = ext + HALF;
    shr    = rnd >>> SHIFT;
    q_word = shr[NUM_BIT-1:0];
    sat    = 1'b0;
    if (shr > MAX_V) begin
      q_word = MAX_V[NUM_BIT-1:0];
      sat    = 1'b1;
    end else if (shr < MIN_V) begin
      q_word = MIN_V[NUM_BIT-1:0];
      sat    = 1'b1;
    end
  end

  // Word-level outputs are forced to zero outside STREAM so reset leaves everything low.
  assign o_valid   = (state_q == STREAM);
  assign o_busy    = (state_q == STREAM);
  assign o_idx     = idx_q;
  assign o_last    = o_valid & idx_last;
  assign o_data    = o_valid ? q_word : '0;
  assign o_sat     = o_valid & sat;
  assign o_done    = done_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_mvm_result_drain.sv
// Directed bench for mvm_result_drain: stream, rounding/saturation, backpressure,
// overrun, back-to-back capture and reset mid-stream.
module tb_mvm_result_drain;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0][15:0]      y_vec;
  logic                  is_acc;
  logic                  ready;
  logic                  valid, last, sat, busy, done, overrun;
  logic [7:0]            data;
  logic [2:0]            idx;

  int total = 0;
  int bad   = 0;

  mvm_result_drain #(.NUM_BIT(8), .DIM(8), .SHIFT(4)) dut (
    .i_clk_drain (clk),
    .i_rst_drain (rst),
    .i_y_vector  (y_vec),
    .i_isAcc     (is_acc),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_data      (data),
    .o_idx       (idx),
    .o_last      (last),
    .o_sat       (sat),
    .o_busy      (busy),
    .o_done      (done),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds isAcc high for three edges and drops it; the next edge is the capture.
  task automatic start_vector(input logic [7:0][15:0] y);
    y_vec  = y;
    is_acc = 1'b1;
    step();
    step();
    step();
    is_acc = 1'b0;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    is_acc = 1'b1;
    ready  = 1'b1;
    y_vec  = '0;
    step();
    step();
    rst    = 1'b0;
    is_acc = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({valid, busy, done, overrun, last, sat} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", {valid, busy, done, overrun, last, sat});
    end
    total++;
    if ({data, idx} !== 11'd0) begin
      bad++;
      $display("[TB] FAIL reset_data_idx: got data=%0h idx=%0d expected 0/0", data, idx);
    end
    step();
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_no_false_fall: got valid=%b expected 0", valid);
    end
  endtask

  task automatic test_basic();
    logic [7:0][15:0] y;
    for (int i = 0; i < 8; i++) y[i] = 16'(16 * i);
    ready = 1'b1;
    start_vector(y);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_valid_early: got %b expected 0", valid);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({valid, busy, last, sat, done} !== {1'b1, 1'b1, (i == 7), 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL basic_flags[%0d]: got v/b/l/s/d=%b expected %b", i,
                 {valid, busy, last, sat, done}, {1'b1, 1'b1, (i == 7), 1'b0, 1'b0});
      end
      total++;
      if (data !== 8'(i) || idx !== 3'(i)) begin
        bad++;
        $display("[TB] FAIL basic_word[%0d]: got data=%0d idx=%0d expected %0d/%0d", i, data, idx, i, i);
      end
      step();
    end
    total++;
    if ({done, valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL basic_done: got done/valid=%b expected 10", {done, valid});
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_rounding();
    logic [7:0][15:0] y;
    logic [7:0][7:0]  exp_d;
    logic [7:0]       exp_s;
    y     = {16'h07F0, 16'hFFF8, 16'h0008, 16'h0007, 16'h8000, 16'h7FFF, 16'hFFE8, 16'h0018};
    exp_d = {8'h7F, 8'h00, 8'h01, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h02};
    exp_s = 8'b0000_1100;
    ready = 1'b1;
    start_vector(y);
    step();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (data !== exp_d[i] || sat !== exp_s[i]) begin
        bad++;
        $display("[TB] FAIL round[%0d]: got data=%0h sat=%b expected %0h/%b", i, data, sat, exp_d[i], exp_s[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0][15:0] y;
    int exp_i = 0;
    int cyc   = 0;
    for (int i = 0; i < 8; i++) y[i] = 16'(16 * (i + 10));
    ready = 1'b1;
    start_vector(y);
    step();
    while (exp_i < 8 && cyc < 40) begin
      ready = (cyc % 3 == 0);
      total++;
      if (valid !== 1'b1 || done !== 1'b0 || idx !== 3'(exp_i) || data !== 8'(exp_i + 10)) begin
        bad++;
        $display("[TB] FAIL bp_word cyc%0d: got v=%b d=%b idx=%0d data=%0d expected 1/0/%0d/%0d",
                 cyc, valid, done, idx, data, exp_i, exp_i + 10);
      end
      step();
      if (ready) exp_i++;
      cyc++;
    end
    total++;
    if (exp_i != 8 || done !== 1'b1 || valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_end: got xfers=%0d done=%b valid=%b expected 8/1/0", exp_i, done, valid);
    end
    ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0][15:0] y1, y2;
    for (int i = 0; i < 8; i++) begin
      y1[i] = 16'(16 * (i + 1));
      y2[i] = 16'(16 * (i + 50));
    end
    ready = 1'b1;
    start_vector(y1);
    step();
    for (int i = 0; i < 6; i++) step();
    is_acc = 1'b1;
    step();
    total++;
    if (idx !== 3'd7 || data !== 8'd8 || last !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_last: got idx=%0d data=%0d last=%b expected 7/8/1", idx, data, last);
    end
    is_acc = 1'b0;
    y_vec  = y2;
    step();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (valid !== 1'b1 || idx !== 3'(i) || data !== 8'(i + 50) || overrun !== 1'b0 || done !== (i == 0)) begin
        bad++;
        $display("[TB] FAIL b2b_word[%0d]: got v=%b idx=%0d data=%0d ovr=%b done=%b expected 1/%0d/%0d/0/%b",
                 i, valid, idx, data, overrun, done, i, i + 50, (i == 0));
      end
      step();
    end
    total++;
    if ({done, valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL b2b_done: got done/valid=%b expected 10", {done, valid});
    end
    step();
  endtask

  task automatic test_overrun();
    logic [7:0][15:0] y1, y2;
    for (int i = 0; i < 8; i++) begin
      y1[i] = 16'(16 * (i + 20));
      y2[i] = 16'(16 * (i + 40));
    end
    ready = 1'b1;
    start_vector(y1);
    step();
    step();
    step();
    step();
    ready  = 1'b0;
    y_vec  = y2;
    is_acc = 1'b1;
    step();
    is_acc = 1'b0;
    step();
    total++;
    if (overrun !== 1'b1 || idx !== 3'd3 || data !== 8'd23) begin
      bad++;
      $display("[TB] FAIL ovr_set: got ovr=%b idx=%0d data=%0d expected 1/3/23", overrun, idx, data);
    end
    ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      total++;
      if (data !== 8'(i + 20) || idx !== 3'(i) || overrun !== 1'b1) begin
        bad++;
        $display("[TB] FAIL ovr_word[%0d]: got data=%0d idx=%0d ovr=%b expected %0d/%0d/1",
                 i, data, idx, overrun, i + 20, i);
      end
      step();
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovr_done: got %b expected 1", done);
    end
    for (int i = 0; i < 4; i++) step();
    total++;
    if (valid !== 1'b0 || overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovr_sticky: got valid=%b ovr=%b expected 0/1", valid, overrun);
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0][15:0] y1, y2;
    for (int i = 0; i < 8; i++) begin
      y1[i] = 16'(16 * (i + 30));
      y2[i] = 16'(16 * (i + 60));
    end
    ready = 1'b1;
    start_vector(y1);
    step();
    for (int i = 0; i < 4; i++) step();
    total++;
    if (idx !== 3'd4 || data !== 8'd34) begin
      bad++;
      $display("[TB] FAIL mid_pre: got idx=%0d data=%0d expected 4/34", idx, data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({valid, busy, done, overrun} !== 4'b0 || idx !== 3'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got v/b/d/o=%b idx=%0d expected 0000/0", {valid, busy, done, overrun}, idx);
    end
    step();
    total++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_no_done: got done=%b valid=%b expected 0/0", done, valid);
    end
    start_vector(y2);
    step();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (valid !== 1'b1 || idx !== 3'(i) || data !== 8'(i + 60)) begin
        bad++;
        $display("[TB] FAIL mid_restream[%0d]: got v=%b idx=%0d data=%0d expected 1/%0d/%0d",
                 i, valid, idx, data, i, i + 60);
      end
      step();
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_restream_done: got %b expected 1", done);
    end
  endtask

  initial begin
    rst    = 1'b1;
    is_acc = 1'b0;
    ready  = 1'b1;
    y_vec  = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mvm_result_drain.md
Name: mvm_result_drain

Overview:
- Sits downstream of the matrix-vector multiply top.
- Captures the parallel y vector when the accumulator signals completion (falling edge of isAcc).
- Requantizes each word to NUM_BIT signed with rounding and saturation.
- Streams the words out one per handshake over valid/ready toward the next layer or writeback.

Parameters:
- NUM_BIT, 8, output word width; the input word width is NUM_BIT+8.
- DIM, 8, number of y words per vector.
- SHIFT, 4, arithmetic right shift applied during requantization (SHIFT ≥ 1).

Ports:
- i_clk_drain  in  1  clock.
- i_rst_drain  in  1  synchronous active-high reset.
- i_y_vector  in  [NUM_BIT+7:0] x DIM  parallel result from the MVM.
- i_isAcc  in  1  MVM busy/accumulating flag; a 1->0 transition marks the vector as valid.
- o_valid  out  1  output word valid.
- i_ready  in  1  consumer ready.
- o_data  out  NUM_BIT  requantized signed word.
- o_idx  out  clog2(DIM)  index of the current word.
- o_last  out  1  high with word DIM-1.
- o_sat  out  1  the current word was saturated.
- o_busy  out  1  in STREAM state.
- o_done  out  1  one-cycle pulse after the last word transfers.
- o_overrun  out  1  sticky: a vector arrived while streaming and was dropped.

Behaviour:
- Reset:
  - Synchronous; all outputs 0, state IDLE, idx 0.
  - Internal isAcc_d is cleared to 0, so a low i_isAcc right after reset is not a fall.
  - Buffer contents are don't-care.
- Fall detect:
  - isAcc_d registers i_isAcc every cycle.
  - cap = isAcc_d & ~i_isAcc, evaluated at each rising edge.
- IDLE:
  - On cap, latch all DIM words of i_y_vector into the buffer, set idx=0 and go to STREAM.
  - o_valid is high from that edge, i.e. one cycle after i_isAcc is first sampled low.
- STREAM:
  - o_valid=1 and o_busy=1.
  - o_data, o_sat and o_last derive combinationally from buffer[idx] and idx; no added latency.
  - Transfer occurs when o_valid & i_ready.
  - On a transfer with idx<DIM-1: idx+1.
  - On a transfer with idx==DIM-1: go to IDLE, idx=0, o_done=1 for exactly the next cycle.
  - With i_ready low, o_data and o_idx hold stable.
- Requantization:
  - Sign-extend the word to NUM_BIT+9 bits and add 2^(SHIFT-1).
  - Arithmetic shift right by SHIFT.
  - Clamp to [-2^(NUM_BIT-1), 2^(NUM_BIT-1)-1].
  - o_sat=1 if the clamp was applied.
- Simultaneous events:
  - cap in the same cycle as the final transfer: accept the new vector, stay in STREAM with idx=0, no overrun. o_done still pulses next cycle.
  - cap in STREAM at any other time: the vector is dropped, the buffer is unchanged, o_overrun is set to 1 and stays until reset.
- Reset mid-stream: returns to IDLE immediately, no o_done, remaining words discarded.

Test Plan:
- Basic stream:
  - Stimulus: reset; y[i]=16*i; pulse i_isAcc high 3 cycles then low; i_ready=1.
  - Required: o_valid one cycle after the fall; o_data=0..7 on consecutive cycles; o_last with idx 7; o_done one cycle later; o_sat=0 throughout.
- Rounding/saturation:
  - Stimulus: y = {0x0018, 0xFFE8, 0x7FFF, 0x8000, 0x0007, 0x0008, 0xFFF8, 0x07F0}.
  - Required o_data: {2, -1, 127, -128, 0, 1, 0, 127}.
  - Required o_sat: {0, 0, 1, 1, 0, 0, 0, 0}.
- Backpressure:
  - Stimulus: toggle i_ready 1,0,0,1,... during the stream.
  - Required: o_data/o_idx stable while i_ready=0; exactly 8 transfers in order; o_done only after the 8th.
- Overrun:
  - Stimulus: second isAcc fall while idx=3 with i_ready=0.
  - Required: o_overrun=1 and sticky; the remaining words are from the first vector; no second stream follows.
- Back-to-back:
  - Stimulus: second fall in the same cycle as the idx=7 transfer.
  - Required: o_valid stays high; idx restarts at 0 with the new data; o_overrun=0; o_done pulses once.
- Reset mid-stream:
  - Stimulus: assert i_rst_drain at idx=4.
  - Required: next cycle o_valid=0, o_busy=0, o_done=0, o_overrun=0; a new fall afterward streams normally from idx 0.
